// File: rtl/snow64_scalar_rmw_sequencer_pkg.sv
// Shared types for the scalar read-modify-write sequencer: CPU data-type and
// int-size encodings, FSM state encoding, and lane geometry helpers.
// Pure declarations; no logic, no latency, no backpressure.

package PkgSnow64Cpu;

  // Scalar data type carried with each request.
  typedef enum logic [1:0] {
    DataTypUnsgnInt = 2'd0,
    DataTypSgnInt   = 2'd1,
    DataTypBFloat16 = 2'd2,
    DataTypReserved = 2'd3
  } data_type_t;

  // Integer operand size; ignored for BFloat16.
  typedef enum logic [1:0] {
    IntTypSz8  = 2'd0,
    IntTypSz16 = 2'd1,
    IntTypSz32 = 2'd2,
    IntTypSz64 = 2'd3
  } int_type_size_t;

endpackage

package PkgSnow64ScalarDataShifter;
  import PkgSnow64Cpu::*;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    MERGE   = 3'd2,
    WRITE   = 3'd3,
    ERR     = 3'd4
  } state_t;

  localparam int LINE_WIDTH   = 256;
  localparam int SCALAR_WIDTH = 64;
  localparam int OFFSET_WIDTH = 5;

  // log2 of the lane width in bytes: 0 -> 8b, 1 -> 16b, 2 -> 32b, 3 -> 64b.
  localparam logic [1:0] LANE_LOG2_B8  = 2'd0;
  localparam logic [1:0] LANE_LOG2_B16 = 2'd1;
  localparam logic [1:0] LANE_LOG2_B32 = 2'd2;
  localparam logic [1:0] LANE_LOG2_B64 = 2'd3;

  // BFloat16 is always a 16-bit lane; integers follow their size field.
  function automatic logic [1:0] lane_log2_bytes(data_type_t dt, int_type_size_t sz);
    logic [1:0] l2;
    l2 = (dt == DataTypBFloat16) ? LANE_LOG2_B16 : 2'(sz);
    return l2;
  endfunction

  // Lane number within the line: byte offset divided by lane bytes.
  function automatic logic [OFFSET_WIDTH-1:0] lane_index(logic [OFFSET_WIDTH-1:0] off,
                                                         logic [1:0] l2);
    return off >> l2;
  endfunction

  // True when the byte offset is not a multiple of the lane size.
  function automatic logic offset_misaligned(logic [OFFSET_WIDTH-1:0] off, logic [1:0] l2);
    logic [OFFSET_WIDTH-1:0] low_bits;
    low_bits = ~(5'h1f << l2);
    return |(off & low_bits);
  endfunction

  // Right-aligned all-ones mask covering one lane.
  function automatic logic [SCALAR_WIDTH-1:0] lane_mask(logic [1:0] l2);
    logic [SCALAR_WIDTH-1:0] m;
    case (l2)
      LANE_LOG2_B8:  m = 64'h0000_0000_0000_00ff;
      LANE_LOG2_B16: m = 64'h0000_0000_0000_ffff;
      LANE_LOG2_B32: m = 64'h0000_0000_ffff_ffff;
      default:       m = 64'hffff_ffff_ffff_ffff;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/snow64_scalar_rmw_sequencer_lane_merge.sv
// Replaces one lane of a 256-bit line with the low bits of a scalar.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs.

module snow64_scalar_lane_merge
  import PkgSnow64Cpu::*;
  import PkgSnow64ScalarDataShifter::*;
(
  input  logic [LINE_WIDTH-1:0]   line_i,
  input  logic [SCALAR_WIDTH-1:0] scalar_i,
  input  data_type_t              data_type_i,
  input  int_type_size_t          int_size_i,
  input  logic [OFFSET_WIDTH-1:0] offset_i,
  output logic [LINE_WIDTH-1:0]   merged_o
);

  logic [1:0]              lane_l2;
  logic [OFFSET_WIDTH-1:0] lane_idx;
  logic [OFFSET_WIDTH-1:0] byte_pos;
  logic [7:0]              bit_pos;
  logic [SCALAR_WIDTH-1:0] lmask;
  logic [LINE_WIDTH-1:0]   field_mask;
  logic [LINE_WIDTH-1:0]   field_dat;

  // Offset bits below the lane size drop out when the lane index is scaled
  // back up, so a misaligned offset lands on its containing lane. Signed and
  // unsigned ints merge identically: the scalar is simply truncated.
  always_comb begin
    lane_l2    = lane_log2_bytes(data_type_i, int_size_i);
    lane_idx   = lane_index(offset_i, lane_l2);
    byte_pos   = OFFSET_WIDTH'(lane_idx << lane_l2);
    bit_pos    = {byte_pos, 3'b000};
    lmask      = lane_mask(lane_l2);
    field_mask = {192'd0, lmask} << bit_pos;
    field_dat  = {192'd0, scalar_i & lmask} << bit_pos;
    merged_o   = (line_i & ~field_mask) | field_dat;
  end

endmodule

// File: rtl/snow64_scalar_rmw_sequencer.sv
// Scalar store into a LAR line: read line, replace one lane, write line back.
// Latency: handshake N -> wr_en/done at N+3 with rd_valid at N+1; ready at N+4.
// Backpressure: req_ready only in IDLE; RD_WAIT stalls until rd_valid.
// Optional: SNOW64_SCALAR_RMW_ALIGN_CHECK_EN rejects offsets not aligned to the lane.

module snow64_scalar_rmw_sequencer
  import PkgSnow64Cpu::*;
  import PkgSnow64ScalarDataShifter::*;
#(
  parameter int LAR_INDEX_WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [LAR_INDEX_WIDTH-1:0] req_lar_index,
  input  logic [63:0]                req_data,
  input  logic [1:0]                 req_data_type,
  input  logic [1:0]                 req_int_type_size,
  input  logic [4:0]                 req_data_offset,
  output logic                       rd_req,
  output logic [LAR_INDEX_WIDTH-1:0] rd_index,
  input  logic                       rd_valid,
  input  logic [255:0]               rd_data,
  output logic                       wr_en,
  output logic [LAR_INDEX_WIDTH-1:0] wr_index,
  output logic [255:0]               wr_data,
  output logic                       done,
  output logic                       err
);

  state_t                     state_q;
  logic                       req_ready_q;
  logic                       rd_req_q;
  logic [LAR_INDEX_WIDTH-1:0] rd_index_q;
  logic                       wr_en_q;
  logic [LAR_INDEX_WIDTH-1:0] wr_index_q;
  logic [LINE_WIDTH-1:0]      wr_data_q;
  logic                       done_q;
  logic                       err_q;

  // Captured request and fetched line.
  logic [LAR_INDEX_WIDTH-1:0] idx_q;
  logic [SCALAR_WIDTH-1:0]    data_q;
  data_type_t                 type_q;
  int_type_size_t             size_q;
  logic [OFFSET_WIDTH-1:0]    offset_q;
  logic [LINE_WIDTH-1:0]      line_q;

  logic                       hs_d;
  logic                       reject_d;
  logic [LINE_WIDTH-1:0]      merged_d;

  // Decide at the handshake whether the request is rejected outright.
  always_comb begin
    hs_d = req_valid & req_ready_q;
`ifdef SNOW64_SCALAR_RMW_ALIGN_CHECK_EN
    reject_d = (data_type_t'(req_data_type) == DataTypReserved) ||
               offset_misaligned(req_data_offset,
                                 lane_log2_bytes(data_type_t'(req_data_type),
                                                 int_type_size_t'(req_int_type_size)));
`else
    reject_d = (data_type_t'(req_data_type) == DataTypReserved);
`endif
  end

  snow64_scalar_lane_merge u_lane_merge (
    .line_i      (line_q),
    .scalar_i    (data_q),
    .data_type_i (type_q),
    .int_size_i  (size_q),
    .offset_i    (offset_q),
    .merged_o    (merged_d)
  );

  // Sequencer FSM; every output is a register set on the transition into its state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      rd_req_q    <= 1'b0;
      rd_index_q  <= '0;
      wr_en_q     <= 1'b0;
      wr_index_q  <= '0;
      wr_data_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      idx_q       <= '0;
      data_q      <= '0;
      type_q      <= DataTypUnsgnInt;
      size_q      <= IntTypSz8;
      offset_q    <= '0;
      line_q      <= '0;
    end else begin
      // Strobes default low so each is a single-cycle pulse.
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (hs_d) begin
            req_ready_q <= 1'b0;
            idx_q       <= req_lar_index;
            data_q      <= req_data;
            type_q      <= data_type_t'(req_data_type);
            size_q      <= int_type_size_t'(req_int_type_size);
            offset_q    <= req_data_offset;
            if (reject_d) begin
              state_q <= ERR;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              state_q    <= RD_WAIT;
              rd_req_q   <= 1'b1;
              rd_index_q <= req_lar_index;
            end
          end
        end
        RD_WAIT: begin
          if (rd_valid) begin
            line_q   <= rd_data;
            rd_req_q <= 1'b0;
            state_q  <= MERGE;
          end
        end
        MERGE: begin
          wr_data_q  <= merged_d;
          wr_index_q <= idx_q;
          wr_en_q    <= 1'b1;
          done_q     <= 1'b1;
          state_q    <= WRITE;
        end
        WRITE: begin
          req_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
        ERR: begin
          req_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: begin
          req_ready_q <= 1'b1;
          rd_req_q    <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rd_req    = rd_req_q;
  assign rd_index  = rd_index_q;
  assign wr_en     = wr_en_q;
  assign wr_index  = wr_index_q;
  assign wr_data   = wr_data_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_snow64_scalar_rmw_sequencer.sv
// Directed vector bench for the scalar RMW sequencer: table of stores with
// hand-computed merged lines, plus hand-written stall, reject and reset cases.
// SNOW64_SCALAR_RMW_ALIGN_CHECK_EN selects the expectation for the misaligned vector.

module tb_snow64_scalar_rmw_sequencer;

  logic         clk;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [3:0]   req_lar_index;
  logic [63:0]  req_data;
  logic [1:0]   req_data_type;
  logic [1:0]   req_int_type_size;
  logic [4:0]   req_data_offset;
  logic         rd_req;
  logic [3:0]   rd_index;
  logic         rd_valid;
  logic [255:0] rd_data;
  logic         wr_en;
  logic [3:0]   wr_index;
  logic [255:0] wr_data;
  logic         done;
  logic         err;

  int tests_run;
  int tests_failed;

  snow64_scalar_rmw_sequencer #(.LAR_INDEX_WIDTH(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_lar_index     (req_lar_index),
    .req_data          (req_data),
    .req_data_type     (req_data_type),
    .req_int_type_size (req_int_type_size),
    .req_data_offset   (req_data_offset),
    .rd_req            (rd_req),
    .rd_index          (rd_index),
    .rd_valid          (rd_valid),
    .rd_data           (rd_data),
    .wr_en             (wr_en),
    .wr_index          (wr_index),
    .wr_data           (wr_data),
    .done              (done),
    .err               (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   dt;
    logic [1:0]   sz;
    logic [4:0]   off;
    logic [63:0]  dat;
    logic [3:0]   idx;
    logic [255:0] line;
    logic [255:0] exp;
    logic         rej;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Full transaction; the call happens in cycle N, rd_valid arrives dly cycles after N+1.
  task automatic run_txn(input int id, input vec_t v, input int dly);
    req_valid         = 1'b1;
    req_lar_index     = v.idx;
    req_data          = v.dat;
    req_data_type     = v.dt;
    req_int_type_size = v.sz;
    req_data_offset   = v.off;
    step();                                   // N+1
    req_valid = 1'b0;
    if (v.rej) begin
      chk($sformatf("v%0d err_done", id), done, 1);
      chk($sformatf("v%0d err_flag", id), err, 1);
      chk($sformatf("v%0d err_rdreq", id), rd_req, 0);
      chk($sformatf("v%0d err_wren", id), wr_en, 0);
      step();                                 // N+2
      chk($sformatf("v%0d err_ready", id), req_ready, 1);
      chk($sformatf("v%0d err_done_drop", id), done, 0);
      chk($sformatf("v%0d err_rdreq2", id), rd_req, 0);
      chk($sformatf("v%0d err_wren2", id), wr_en, 0);
      return;
    end
    chk($sformatf("v%0d rd_req", id), rd_req, 1);
    chk($sformatf("v%0d rd_index", id), rd_index, v.idx);
    chk($sformatf("v%0d busy", id), req_ready, 0);
    for (int i = 0; i < dly; i++) begin
      step();
      chk($sformatf("v%0d rd_req_hold%0d", id, i), rd_req, 1);
      chk($sformatf("v%0d no_early_wr%0d", id, i), wr_en, 0);
    end
    rd_valid = 1'b1;
    rd_data  = v.line;
    step();                                   // MERGE
    rd_valid = 1'b0;
    rd_data  = {4{64'h0123_4567_89ab_cdef}};
    chk($sformatf("v%0d merge_wren", id), wr_en, 0);
    chk($sformatf("v%0d merge_rdreq", id), rd_req, 0);
    step();                                   // WRITE at N+3+dly
    chk($sformatf("v%0d wr_en", id), wr_en, 1);
    chk($sformatf("v%0d done", id), done, 1);
    chk($sformatf("v%0d err", id), err, 0);
    chk($sformatf("v%0d wr_index", id), wr_index, v.idx);
    chk($sformatf("v%0d wr_data", id), wr_data, v.exp);
    step();                                   // IDLE
    chk($sformatf("v%0d ready", id), req_ready, 1);
    chk($sformatf("v%0d wr_en_drop", id), wr_en, 0);
    chk($sformatf("v%0d done_drop", id), done, 0);
    chk($sformatf("v%0d wr_data_hold", id), wr_data, v.exp);
  endtask

  initial begin
    logic [255:0] ones;
    logic [255:0] a5;
    vec_t         v;
    ones = {256{1'b1}};
    a5   = {32{8'ha5}};
    tests_run    = 0;
    tests_failed = 0;

    // Int16 @6 into zeros -> bits [63:48]
    vecs[0] = '{2'd0, 2'd1, 5'd6, 64'h0000_0000_0000_beef, 4'd3, 256'd0,
                256'hbeef << 48, 1'b0};
    // SgnInt8 @31, data 0x1A5 truncated to A5 -> bits [255:248]
    vecs[1] = '{2'd1, 2'd0, 5'd31, 64'h0000_0000_0000_01a5, 4'd9, ones,
                {8'ha5, {248{1'b1}}}, 1'b0};
    // BFloat16 @8 (size field ignored) -> lane 4, bits [79:64]
    vecs[2] = '{2'd2, 2'd3, 5'd8, 64'h1234_5678_9abc_3f80, 4'd5, 256'd0,
                256'h3f80 << 64, 1'b0};
    // Int64 @24 -> bits [255:192]
    vecs[3] = '{2'd0, 2'd3, 5'd24, 64'hdead_beef_cafe_f00d, 4'd15, a5,
                {64'hdead_beef_cafe_f00d, {24{8'ha5}}}, 1'b0};
    // Int32 @2: misaligned
`ifdef SNOW64_SCALAR_RMW_ALIGN_CHECK_EN
    vecs[4] = '{2'd1, 2'd2, 5'd2, 64'hffff_ffff_1122_3344, 4'd7, ones,
                ones, 1'b1};
`else
    vecs[4] = '{2'd1, 2'd2, 5'd2, 64'hffff_ffff_1122_3344, 4'd7, ones,
                {{224{1'b1}}, 32'h1122_3344}, 1'b0};
`endif
    // Int32 @16 -> lane 4, bits [159:128]
    vecs[5] = '{2'd0, 2'd2, 5'd16, 64'h0000_0000_cafe_babe, 4'd1, 256'd0,
                256'hcafe_babe << 128, 1'b0};
    // Reserved type -> reject
    vecs[6] = '{2'd3, 2'd0, 5'd0, 64'h0000_0000_0000_0055, 4'd2, 256'd0,
                256'd0, 1'b1};
    // Int8 @0 into alternating pattern
    vecs[7] = '{2'd0, 2'd0, 5'd0, 64'hffff_ffff_ffff_ff7f, 4'd0, a5,
                {{31{8'ha5}}, 8'h7f}, 1'b0};

    req_valid = 1'b0; req_lar_index = '0; req_data = '0;
    req_data_type = '0; req_int_type_size = '0; req_data_offset = '0;
    rd_valid = 1'b0; rd_data = '0;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    chk("rst_ready", req_ready, 1);
    chk("rst_rd_req", rd_req, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_rd_index", rd_index, 0);
    chk("rst_wr_index", wr_index, 0);
    chk("rst_wr_data", wr_data, 0);

    // rd_valid in IDLE must not start anything.
    rd_valid = 1'b1; rd_data = ones;
    step();
    rd_valid = 1'b0;
    chk("idle_rdv_wren", wr_en, 0);
    chk("idle_rdv_done", done, 0);
    chk("idle_rdv_ready", req_ready, 1);

    for (int i = 0; i < 8; i++) run_txn(i, vecs[i], 0);

    // Read data delayed 5 cycles: rd_req held, write at N+8.
    v = '{2'd0, 2'd1, 5'd10, 64'h0000_0000_0000_a1b2, 4'd12, 256'd0,
          256'ha1b2 << 80, 1'b0};
    run_txn(100, v, 5);

    // Reset during the second RD_WAIT cycle aborts the store.
    req_valid = 1'b1; req_lar_index = 4'd6; req_data = 64'h77;
    req_data_type = 2'd0; req_int_type_size = 2'd0; req_data_offset = 5'd3;
    step();                                   // N+1, RD_WAIT cycle 1
    req_valid = 1'b0;
    chk("abort_rd_req", rd_req, 1);
    step();                                   // N+2, RD_WAIT cycle 2
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_ready", req_ready, 1);
    chk("abort_rd_req_clr", rd_req, 0);
    chk("abort_wr_data", wr_data, 0);
    for (int i = 0; i < 4; i++) begin
      rd_valid = (i == 0);
      rd_data  = ones;
      chk($sformatf("abort_no_wr%0d", i), wr_en, 0);
      chk($sformatf("abort_no_done%0d", i), done, 0);
      step();
    end
    rd_valid = 1'b0;
    chk("abort_idle_ready", req_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
